cust_cam_arb: RTL and testbench

Shared-access controller for the `cust_cam` lookup table. It zero-initialises the table after reset. It then round-robin arbitrates up to NUM_REQ read requesters onto the table's single read port, passes one writer through to the write port, and blocks same-address read/write collisions. It sits between the RDMA/CXL request engines and the table instance.

---
 rtl/cust_cam_arb.sv | 162 ++++++++++++++++
 tb/tb_cust_cam_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cust_cam_arb.sv
// cust_cam_arb: shared-access controller for the cust_cam lookup table.
// Clears the table after reset, then round-robin arbitrates NUM_REQ read
// requesters onto the single read port, passes one writer through to the
// write port, and masks any read aimed at the index being written that cycle.
module cust_cam_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    input  logic                          wr_valid,
    input  logic [ADDR_WIDTH-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    output logic                          init_done,
    output logic                          mem_rd_req,
    output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          mem_wr_req,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [PW-1:0]           ptr_r;
    logic [NUM_REQ-1:0]      resp_id_r;
    logic                    init_done_r;

    logic                    run_s;
    logic                    init_s;
    logic [NUM_REQ-1:0]      elig_s;
    logic                    found_s;
    logic [PW-1:0]           win_s;
    logic [NUM_REQ-1:0]      grant_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;

    // rst gates every strobe so nothing leaks out while reset is held,
    // including the cycle in which it is first asserted.
    assign run_s  = (state_r == ST_RUN)  && !rst;
    assign init_s = (state_r == ST_INIT) && !rst;

    // Eligibility: a valid requester is masked if the writer targets its index.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !(wr_valid && (req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr))) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
    end

    // Round-robin pick: first eligible requester scanning from the pointer.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_r) + k) % NUM_REQ;
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                win_s   = PW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant vector, only while running.
    always_comb begin
        grant_s = '0;
        if (run_s && found_s) begin
            grant_s = NUM_REQ'(1) << win_s;
        end else begin
            grant_s = '0;
        end
    end

    // Select the winner's index for the table read port.
    always_comb begin
        win_addr_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == win_s) begin
                win_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Controller FSM: table clear sweep, then arbitration pointer and response id.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            clr_cnt_r   <= '0;
            ptr_r       <= '0;
            resp_id_r   <= '0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    resp_id_r <= '0;
                    clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
                    if (clr_cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    resp_id_r <= grant_s;
                    if (found_s) begin
                        ptr_r <= (win_s == PW'(NUM_REQ - 1)) ? PW'(0) : win_s + PW'(1);
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    clr_cnt_r   <= '0;
                    ptr_r       <= '0;
                    resp_id_r   <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = grant_s;
    assign mem_rd_req  = run_s && found_s;
    assign mem_rd_addr = win_addr_s;

    // Table read data is registered one cycle, lining up with the response id.
    assign resp_valid  = rst ? '0 : resp_id_r;
    assign resp_data   = mem_rd_data;

    assign wr_ready    = run_s;
    assign mem_wr_req  = init_s || (run_s && wr_valid);
    assign mem_wr_addr = init_s ? clr_cnt_r : wr_addr;
    assign mem_wr_data = init_s ? '0 : wr_data;

    assign init_done   = init_done_r && !rst;

endmodule

// File: tb/tb_cust_cam_arb.sv
// Bench for cust_cam_arb: a behavioural table stand-in, a spec-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_cust_cam_arb;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int DW = 64;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [DW-1:0]     resp_data;
    logic              wr_valid;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic              init_done;
    logic              mem_rd_req;
    logic [AW-1:0]     mem_rd_addr;
    logic [DW-1:0]     mem_rd_data;
    logic              mem_wr_req;
    logic [AW-1:0]     mem_wr_addr;
    logic [DW-1:0]     mem_wr_data;

    int checks = 0;
    int errors = 0;

    cust_cam_arb #(.NUM_REQ(N), .DEPTH(D), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .init_done(init_done),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Table stand-in: 1-cycle registered read, write on request. Starts with garbage.
    logic [DW-1:0] tbl [D];
    initial begin
        mem_rd_data = '0;
        for (int i = 0; i < D; i++) tbl[i] = 64'hBAD0_0000_0000_0000 | 64'(i);
    end
    always @(posedge clk) begin
        if (mem_wr_req) tbl[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_req) mem_rd_data <= tbl[mem_rd_addr];
    end

    // Spec-level model: phase counter, pointer, expected table, pending response.
    int            m_init = 0;
    int            m_ptr  = 0;
    logic [N-1:0]  m_resp = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [DW-1:0] m_mem [D];

    always @(negedge clk) begin
        logic [N-1:0]  g;
        int            w;
        logic [AW-1:0] ai;
        if (rst) begin
            chk("m_rst_req_ready",  64'(req_ready),  64'd0);
            chk("m_rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("m_rst_wr_ready",   64'(wr_ready),   64'd0);
            chk("m_rst_init_done",  64'(init_done),  64'd0);
            chk("m_rst_mem_rd_req", 64'(mem_rd_req), 64'd0);
            chk("m_rst_mem_wr_req", 64'(mem_wr_req), 64'd0);
            m_init = 0;
            m_ptr  = 0;
            m_resp = '0;
        end else if (m_init < D) begin
            chk("m_init_wr_req",     64'(mem_wr_req),  64'd1);
            chk("m_init_wr_addr",    64'(mem_wr_addr), 64'(m_init));
            chk("m_init_wr_data",    mem_wr_data,      64'd0);
            chk("m_init_req_ready",  64'(req_ready),   64'd0);
            chk("m_init_wr_ready",   64'(wr_ready),    64'd0);
            chk("m_init_rd_req",     64'(mem_rd_req),  64'd0);
            chk("m_init_init_done",  64'(init_done),   64'd0);
            chk("m_init_resp_valid", 64'(resp_valid),  64'd0);
            m_mem[m_init] = '0;
            m_init++;
            m_resp = '0;
        end else begin
            g = '0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i  = (m_ptr + k) % N;
                ai = req_addr[i*AW +: AW];
                if (w < 0 && req_valid[i] && !(wr_valid && ai == wr_addr)) w = i;
            end
            if (w >= 0) g[w] = 1'b1;
            chk("m_run_init_done",  64'(init_done),  64'd1);
            chk("m_run_wr_ready",   64'(wr_ready),   64'd1);
            chk("m_run_wr_req",     64'(mem_wr_req), 64'(wr_valid));
            if (wr_valid) begin
                chk("m_run_wr_addr", 64'(mem_wr_addr), 64'(wr_addr));
                chk("m_run_wr_data", mem_wr_data,      wr_data);
            end
            chk("m_run_req_ready",  64'(req_ready),  64'(g));
            chk("m_run_rd_req",     64'(mem_rd_req), 64'(w >= 0));
            if (w >= 0) chk("m_run_rd_addr", 64'(mem_rd_addr), 64'(req_addr[w*AW +: AW]));
            chk("m_run_resp_valid", 64'(resp_valid), 64'(m_resp));
            if (m_resp != '0) chk("m_run_resp_data", resp_data, m_rdata);
            m_resp = g;
            if (w >= 0) begin
                m_rdata = m_mem[req_addr[w*AW +: AW]];
                m_ptr   = (w + 1) % N;
            end
            if (wr_valid) m_mem[wr_addr] = wr_data;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        req_addr  = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a);
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = a;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next();
        next();
        @(negedge clk);
        chk("rst_mem_wr_req", 64'(mem_wr_req), 64'd0);
        chk("rst_req_ready",  64'(req_ready),  64'd0);
        next();

        // Reset release: 16 clearing cycles
        rst = 1'b0;
        for (int c = 0; c < D; c++) begin
            @(negedge clk);
            chk("init_addr", 64'(mem_wr_addr), 64'(c));
            chk("init_req",  64'(mem_wr_req),  64'd1);
            next();
        end

        // Cycle 16: init_done, requester 1 reads addr 5 (garbage must be cleared)
        set_req(1, 4'd5);
        @(negedge clk);
        chk("init_done_at_16", 64'(init_done), 64'd1);
        chk("read5_grant", 64'(req_ready), 64'h2);
        next();
        idle();
        @(negedge clk);
        chk("read5_resp_valid", 64'(resp_valid), 64'h2);
        chk("read5_resp_data",  resp_data,       64'd0);
        next();

        // Write addr 3 then requester 2 reads it
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        chk("wr3_ready", 64'(wr_ready), 64'd1);
        next();
        idle();
        set_req(2, 4'd3);
        @(negedge clk);
        chk("rd3_grant", 64'(req_ready), 64'h4);
        next();
        idle();
        @(negedge clk);
        chk("rd3_resp_valid", 64'(resp_valid), 64'h4);
        chk("rd3_resp_data",  resp_data,       64'h0000_0000_DEAD_BEEF);
        next();

        // Requester 3 alone: single grant, pointer wraps to 0
        set_req(3, 4'd0);
        @(negedge clk);
        chk("r3_grant", 64'(req_ready), 64'h8);
        next();

        // Fairness: all requesters valid, distinct addresses
        idle();
        for (int i = 0; i < N; i++) set_req(i, AW'(i));
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("fair_grant", 64'(req_ready), 64'(1) << (j % N));
            next();
        end
        idle();

        // Hazard: write addr 7 while req0@7 and req1@9 valid, pointer 0
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 64'h1234_5678_9ABC_DEF0;
        set_req(0, 4'd7);
        set_req(1, 4'd9);
        @(negedge clk);
        chk("haz_grant", 64'(req_ready), 64'h2);
        next();
        idle();
        set_req(0, 4'd7);
        @(negedge clk);
        chk("haz_retry_grant", 64'(req_ready), 64'h1);
        next();
        idle();
        @(negedge clk);
        chk("haz_resp_valid", 64'(resp_valid), 64'h1);
        chk("haz_resp_data",  resp_data,       64'h1234_5678_9ABC_DEF0);
        next();

        // Reset mid-traffic
        wr_valid = 1'b1; wr_addr = 4'd10; wr_data = 64'h0000_0000_0000_CAFE;
        next();
        idle();
        set_req(1, 4'd10);
        @(negedge clk);
        chk("pre_rst_grant", 64'(req_ready), 64'h2);
        next();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_init_done",  64'(init_done),  64'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("reinit_wr_req",   64'(mem_wr_req),  64'd1);
        chk("reinit_wr_addr",  64'(mem_wr_addr), 64'd0);
        chk("reinit_done_low", 64'(init_done),   64'd0);
        chk("reinit_resp",     64'(resp_valid),  64'd0);
        for (int c = 0; c < D; c++) next();
        set_req(0, 4'd10);
        @(negedge clk);
        chk("post_rst_done",  64'(init_done), 64'd1);
        chk("post_rst_grant", 64'(req_ready), 64'h1);
        next();
        idle();
        @(negedge clk);
        chk("post_rst_resp_valid", 64'(resp_valid), 64'h1);
        chk("post_rst_resp_data",  resp_data,        64'd0);
        next();

        // Single requester streamed every cycle
        set_req(2, 4'd3);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("single_grant", 64'(req_ready), 64'h4);
            if (j > 0) chk("single_resp", 64'(resp_valid), 64'h4);
            next();
        end
        idle();
        next();
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
